// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage between the PC register and the ID stage. Issues one
// request at a time to instruction memory, loads the IF/ID pipeline register,
// and tells the PC path to hold (if_stall) whenever no instruction is being
// handed to ID this cycle.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cpu_en                   global run enable
//   pc, nextPc               current PC and the value it loads at the coming edge
//   id_shouldStall           ID cannot take a new instruction
//   ex_shouldJumpOrBranch    flush; the PC loads the branch target at this edge
//   imem_req/addr            request to instruction memory (held until ack)
//   imem_ack/rdata           memory response
//   if_stall                 PC must hold this cycle (combinational)
//   id_valid/inst/pc         IF/ID pipeline register
// -----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] NOP_INST = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_en,
    input  logic [31:0] pc,
    input  logic [31:0] nextPc,
    input  logic        id_shouldStall,
    input  logic        ex_shouldJumpOrBranch,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_stall,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DROP = 2'd2;  // flushed request still waiting for its ack
    localparam logic [1:0] HOLD = 2'd3;  // word parked in buf_inst while ID is busy

    logic [1:0]  state_reg, state_next;
    logic [31:0] req_addr_reg, req_addr_next;
    logic [31:0] buf_inst_reg, buf_inst_next;
    logic        id_valid_reg;
    logic [31:0] id_inst_reg, id_pc_reg;

    logic        flush;
    logic        accept;
    logic [31:0] fetched_inst;

    assign flush  = cpu_en & ex_shouldJumpOrBranch;
    // An instruction moves into IF/ID only when one is available (fresh ack or
    // parked buffer) and nothing upstream or downstream objects.
    assign accept = cpu_en & ~flush & ~id_shouldStall &
                    (((state_reg == REQ) & imem_ack) | (state_reg == HOLD));

    // Kept independent of imem_rdata so the PC stall path stays short.
    assign if_stall  = ~accept;
    assign imem_req  = (state_reg == REQ) | (state_reg == DROP);
    assign imem_addr = req_addr_reg;

    assign fetched_inst = (state_reg == HOLD) ? buf_inst_reg : imem_rdata;

    always_comb begin
        state_next    = state_reg;
        req_addr_next = req_addr_reg;
        buf_inst_next = buf_inst_reg;
        case (state_reg)
            IDLE: begin
                if (cpu_en) begin
                    req_addr_next = pc;
                    state_next    = REQ;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    if (flush) begin
                        state_next = IDLE;
                    end else if (accept) begin
                        // Back-to-back: the PC advances this edge, so fetch nextPc.
                        req_addr_next = nextPc;
                    end else begin
                        // ID stalled or run disabled: keep the word, finish the bus cycle.
                        buf_inst_next = imem_rdata;
                        state_next    = HOLD;
                    end
                end else if (flush) begin
                    // Address must stay put until the outstanding ack arrives.
                    state_next = DROP;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    state_next = IDLE;
                end
            end
            HOLD: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (accept) begin
                    req_addr_next = nextPc;
                    state_next    = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            req_addr_reg <= 32'd0;
            buf_inst_reg <= 32'd0;
            id_valid_reg <= 1'b0;
            id_inst_reg  <= 32'd0;
            id_pc_reg    <= 32'd0;
        end else begin
            state_reg    <= state_next;
            req_addr_reg <= req_addr_next;
            buf_inst_reg <= buf_inst_next;

            // IF/ID update: run-disable freezes, flush beats stall.
            if (!cpu_en) begin
                id_valid_reg <= id_valid_reg;
            end else if (flush) begin
                id_valid_reg <= 1'b0;
                id_inst_reg  <= NOP_INST;
                id_pc_reg    <= 32'd0;
            end else if (id_shouldStall) begin
                id_valid_reg <= id_valid_reg;
            end else if (accept) begin
                id_valid_reg <= 1'b1;
                id_inst_reg  <= fetched_inst;
                id_pc_reg    <= req_addr_reg;
            end else begin
                // Bubble: id_pc keeps its last value.
                id_valid_reg <= 1'b0;
                id_inst_reg  <= NOP_INST;
            end
        end
    end

    assign id_valid = id_valid_reg;
    assign id_inst  = id_inst_reg;
    assign id_pc    = id_pc_reg;

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Surrounds the fetch unit with a PC register model and a variable-latency
// memory returning addr ^ KEY. A monitor checks every cycle that ID receives
// the program in order (sequential from the last reset/flush target), that
// IF/ID holds or bubbles when it should, and that request addresses stay
// stable until ack. Directed scenarios check exact cycle timing, followed by
// a randomized run.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] KEY = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_en = 1'b0;
    logic        id_shouldStall = 1'b0;
    logic        ex_shouldJumpOrBranch = 1'b0;
    logic [31:0] target = 32'd0;
    logic [31:0] pc;
    logic [31:0] nextPc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_stall;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    int waits = 0;
    int cnt;
    int n_cmp = 0;
    int n_bad = 0;
    int delivered = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(.NOP_INST(NOP)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .cpu_en                (cpu_en),
        .pc                    (pc),
        .nextPc                (nextPc),
        .id_shouldStall        (id_shouldStall),
        .ex_shouldJumpOrBranch (ex_shouldJumpOrBranch),
        .imem_req              (imem_req),
        .imem_addr             (imem_addr),
        .imem_ack              (imem_ack),
        .imem_rdata            (imem_rdata),
        .if_stall              (if_stall),
        .id_valid              (id_valid),
        .id_inst               (id_inst),
        .id_pc                 (id_pc)
    );

    // PC register: branch target on flush, +4 when fetch does not stall.
    assign nextPc = !cpu_en ? pc :
                    ex_shouldJumpOrBranch ? target :
                    if_stall ? pc : pc + 32'd4;
    always_ff @(posedge clk) begin
        if (rst) pc <= 32'd0;
        else     pc <= nextPc;
    end

    // Memory: acks once the request has waited `waits` cycles.
    always_ff @(posedge clk) begin
        if (rst || !imem_req || imem_ack) cnt <= 0;
        else                              cnt <= cnt + 1;
    end
    assign imem_ack   = imem_req && (cnt >= waits);
    assign imem_rdata = imem_ack ? (imem_addr ^ KEY) : 32'hDEADBEEF;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- per-cycle monitor / reference model ----------------
    logic        p_rst, p_en, p_flush, p_stall, p_req, p_ack, p_valid;
    logic [31:0] p_target, p_inst, p_pc, p_addr;
    logic [31:0] exp_pc = 32'd0;

    always @(posedge clk) begin
        p_rst    = rst;
        p_en     = cpu_en;
        p_flush  = cpu_en & ex_shouldJumpOrBranch;
        p_stall  = id_shouldStall;
        p_req    = imem_req;
        p_ack    = imem_ack;
        p_valid  = id_valid;
        p_target = target;
        p_inst   = id_inst;
        p_pc     = id_pc;
        p_addr   = imem_addr;
        #2;
        if (p_rst) begin
            check_eq("mon_rst_valid", 32'(id_valid), 32'd0);
            check_eq("mon_rst_inst", id_inst, 32'd0);
            check_eq("mon_rst_pc", id_pc, 32'd0);
            check_eq("mon_rst_req", 32'(imem_req), 32'd0);
            exp_pc = 32'd0;
        end else begin
            if (p_req && !p_ack) begin
                check_eq("mon_req_held", 32'(imem_req), 32'd1);
                check_eq("mon_addr_stable", imem_addr, p_addr);
            end
            if (!p_en || (p_stall && !p_flush)) begin
                check_eq("mon_hold_valid", 32'(id_valid), 32'(p_valid));
                check_eq("mon_hold_inst", id_inst, p_inst);
                check_eq("mon_hold_pc", id_pc, p_pc);
            end else if (p_flush) begin
                check_eq("mon_flush_valid", 32'(id_valid), 32'd0);
                check_eq("mon_flush_inst", id_inst, NOP);
                check_eq("mon_flush_pc", id_pc, 32'd0);
                exp_pc = p_target;
            end else if (id_valid) begin
                $display("deliver pc=%h inst=%h", id_pc, id_inst);
                check_eq("mon_order_pc", id_pc, exp_pc);
                check_eq("mon_order_inst", id_inst, exp_pc ^ KEY);
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end else begin
                check_eq("mon_bubble_inst", id_inst, NOP);
                check_eq("mon_bubble_pc", id_pc, p_pc);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cpu_en = 1'b0; id_shouldStall = 1'b0;
        ex_shouldJumpOrBranch = 1'b0; waits = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    logic [31:0] a, snap_pc, snap_inst;
    bit          found;
    int          cool;

    initial begin
        // Reset values and zero-wait streaming.
        do_reset();
        check_eq("rst_valid", 32'(id_valid), 32'd0);
        check_eq("rst_inst", id_inst, 32'd0);
        check_eq("rst_pc", id_pc, 32'd0);
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_addr", imem_addr, 32'd0);
        check_eq("rst_stall", 32'(if_stall), 32'd1);
        cpu_en = 1'b1;
        step();
        check_eq("first_req", 32'(imem_req), 32'd1);
        check_eq("first_addr", imem_addr, 32'd0);
        check_eq("first_stall", 32'(if_stall), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("zw_valid", 32'(id_valid), 32'd1);
            check_eq("zw_pc", id_pc, 32'(i * 4));
            check_eq("zw_inst", id_inst, 32'(i * 4) ^ KEY);
        end

        // Three wait states per request.
        waits = 3;
        #1;
        a = 32'd16;
        for (int r = 0; r < 2; r++) begin
            for (int w = 0; w < 3; w++) begin
                check_eq("w3_addr", imem_addr, a);
                check_eq("w3_stall", 32'(if_stall), 32'd1);
                step();
                check_eq("w3_bubble_valid", 32'(id_valid), 32'd0);
                check_eq("w3_bubble_inst", id_inst, NOP);
            end
            check_eq("w3_addr_ack", imem_addr, a);
            check_eq("w3_stall_ack", 32'(if_stall), 32'd0);
            step();
            check_eq("w3_valid", 32'(id_valid), 32'd1);
            check_eq("w3_pc", id_pc, a);
            check_eq("w3_inst", id_inst, a ^ KEY);
            a = a + 32'd4;
        end

        // Ack while ID stalled: park in HOLD, release without refetch.
        waits = 0;
        id_shouldStall = 1'b1;
        #1;
        check_eq("hold_ack", 32'(imem_ack), 32'd1);
        check_eq("hold_stall", 32'(if_stall), 32'd1);
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq("hold_req", 32'(imem_req), 32'd0);
            check_eq("hold_id_pc", id_pc, a - 32'd4);
        end
        id_shouldStall = 1'b0;
        #1;
        check_eq("hold_release_stall", 32'(if_stall), 32'd0);
        step();
        check_eq("hold_out_valid", 32'(id_valid), 32'd1);
        check_eq("hold_out_pc", id_pc, a);
        check_eq("hold_out_inst", id_inst, a ^ KEY);
        check_eq("hold_next_addr", imem_addr, a + 32'd4);
        check_eq("hold_next_req", 32'(imem_req), 32'd1);

        // Flush while waiting on 0x10, branch to 0x40.
        do_reset();
        cpu_en = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (imem_req && imem_addr == 32'h10) found = 1'b1;
        end
        check_eq("fl_found_0x10", 32'(found), 32'd1);
        waits = 3;
        ex_shouldJumpOrBranch = 1'b1;
        target = 32'h40;
        #1;
        check_eq("fl_stall", 32'(if_stall), 32'd1);
        step();
        ex_shouldJumpOrBranch = 1'b0;
        check_eq("fl_addr_kept", imem_addr, 32'h10);
        check_eq("fl_req_kept", 32'(imem_req), 32'd1);
        check_eq("fl_valid", 32'(id_valid), 32'd0);
        check_eq("fl_inst", id_inst, NOP);
        check_eq("fl_pc", id_pc, 32'd0);
        found = 1'b0;
        for (int k = 0; k < 30 && !id_valid; k++) begin
            if (imem_req && imem_addr != 32'h10) begin
                check_eq("fl_next_req", imem_addr, 32'h40);
                found = 1'b1;
            end
            step();
        end
        check_eq("fl_saw_target_req", 32'(found), 32'd1);
        check_eq("fl_first_valid", 32'(id_valid), 32'd1);
        check_eq("fl_first_pc", id_pc, 32'h40);
        check_eq("fl_first_inst", id_inst, 32'h40 ^ KEY);

        // Flush together with ID stall while in HOLD.
        do_reset();
        cpu_en = 1'b1;
        repeat (3) step();
        id_shouldStall = 1'b1;
        step();
        check_eq("hf_in_hold", 32'(imem_req), 32'd0);
        ex_shouldJumpOrBranch = 1'b1;
        target = 32'h80;
        #1;
        check_eq("hf_stall", 32'(if_stall), 32'd1);
        step();
        ex_shouldJumpOrBranch = 1'b0;
        id_shouldStall = 1'b0;
        #1;
        check_eq("hf_valid", 32'(id_valid), 32'd0);
        check_eq("hf_inst", id_inst, NOP);
        check_eq("hf_idle", 32'(imem_req), 32'd0);
        step();
        check_eq("hf_req", 32'(imem_req), 32'd1);
        check_eq("hf_addr", imem_addr, 32'h80);

        // Reset in the middle of an outstanding request.
        waits = 3;
        step();
        check_eq("mr_waiting", 32'(imem_req), 32'd1);
        rst = 1'b1;
        step();
        check_eq("mr_req", 32'(imem_req), 32'd0);
        check_eq("mr_valid", 32'(id_valid), 32'd0);
        check_eq("mr_inst", id_inst, 32'd0);
        check_eq("mr_pc", id_pc, 32'd0);
        check_eq("mr_addr", imem_addr, 32'd0);
        check_eq("mr_stall", 32'(if_stall), 32'd1);
        rst = 1'b0;

        // cpu_en low for 5 cycles mid-stream.
        waits = 2;
        for (int k = 0; k < 20 && !id_valid; k++) step();
        check_eq("en_got_valid", 32'(id_valid), 32'd1);
        snap_pc = id_pc;
        snap_inst = id_inst;
        cpu_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("en_stall", 32'(if_stall), 32'd1);
            step();
            check_eq("en_frozen_pc", id_pc, snap_pc);
            check_eq("en_frozen_inst", id_inst, snap_inst);
        end
        check_eq("en_hold_req", 32'(imem_req), 32'd0);
        cpu_en = 1'b1;
        step();
        check_eq("en_resume_valid", 32'(id_valid), 32'd1);
        check_eq("en_resume_pc", id_pc, snap_pc + 32'd4);

        // Randomized run; the monitor checks every cycle.
        do_reset();
        cool = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            cpu_en = ($urandom % 8) != 0;
            id_shouldStall = ($urandom % 4) == 0;
            waits = int'($urandom % 4);
            if (cool > 0) cool--;
            // Branches only resolve behind a real instruction.
            if (id_valid && cool == 0 && ($urandom % 12) == 0) begin
                ex_shouldJumpOrBranch = 1'b1;
                target = 32'($urandom_range(0, 1023)) << 2;
                cool = 3;
            end else begin
                ex_shouldJumpOrBranch = 1'b0;
            end
        end
        @(negedge clk);
        ex_shouldJumpOrBranch = 1'b0;
        check_eq("rand_progress", 32'(delivered > 200), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage sitting between the program counter register and the ID stage of the pipelined CPU. It consumes the PC value and its next-PC, drives a request/acknowledge port to instruction memory, and loads the IF/ID pipeline register. It returns a fetch stall to the PC path: the top level ORs `if_stall` into the PC register's stall input. It also handles branch flushes and instructions that arrive while ID is stalled.

## Interface

Parameters:
- `NOP_INST`, default 32'h00000000: instruction word inserted on bubbles and flushes.

Ports:
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `cpu_en`, input, 1: global run enable.
- `pc`, input, 32: current PC register value.
- `nextPc`, input, 32: value the PC register loads at the coming edge.
- `id_shouldStall`, input, 1: ID stage cannot accept a new instruction.
- `ex_shouldJumpOrBranch`, input, 1: flush; the PC loads the target at this edge.
- `imem_req`, output, 1: instruction memory request, held until ack.
- `imem_addr`, output, 32: request address, stable while `imem_req`=1.
- `imem_ack`, input, 1: read data valid this cycle; only legal while `imem_req`=1.
- `imem_rdata`, input, 32: instruction word, sampled only when `imem_ack`=1.
- `if_stall`, output, 1: PC must hold this cycle (combinational).
- `id_valid`, output, 1: IF/ID holds a real instruction.
- `id_inst`, output, 32: IF/ID instruction.
- `id_pc`, output, 32: address of `id_inst`.

## Operation

States: IDLE, REQ, DROP, HOLD. Registers: `req_addr`, `buf_inst`.

Outputs by state:
- `imem_req` = 1 in REQ and DROP; 0 in IDLE and HOLD.
- `imem_addr` = `req_addr` in all states.

Definitions:
- flush = `cpu_en` & `ex_shouldJumpOrBranch`.
- accept = `cpu_en` & !flush & !`id_shouldStall` & ((REQ & `imem_ack`) | HOLD).
- `if_stall` = !accept.

State transitions:
- IDLE: if `cpu_en`, capture `req_addr` <= `pc` and go to REQ. Otherwise stay.
- REQ, ack with flush: discard the data and go to IDLE.
- REQ, ack with accept: load IF/ID, capture `req_addr` <= `nextPc`, and stay in REQ (back-to-back fetch).
- REQ, ack with `id_shouldStall` or `cpu_en`=0: `buf_inst` <= `imem_rdata`, go to HOLD.
- REQ, no ack, flush: go to DROP. `req_addr` is unchanged because the address must stay stable until ack.
- REQ, no ack, no flush: stay in REQ.
- DROP: on ack, discard the data and go to IDLE. A further flush while in DROP keeps the state DROP.
- HOLD: flush discards the buffer and goes to IDLE. Accept loads IF/ID from `buf_inst`, captures `req_addr` <= `nextPc`, and goes to REQ. Otherwise stay.

IF/ID register update, by priority:
1. `cpu_en`=0: hold.
2. flush: `id_valid` <= 0, `id_inst` <= `NOP_INST`, `id_pc` <= 0.
3. `id_shouldStall`: hold.
4. accept: `id_valid` <= 1, `id_inst` <= rdata (from REQ) or `buf_inst` (from HOLD), `id_pc` <= `req_addr`.
5. Otherwise (bubble): `id_valid` <= 0, `id_inst` <= `NOP_INST`, `id_pc` held.

Notes:
- Flush overrides stall, matching the PC register's behaviour.
- `cpu_en`=0 never aborts an outstanding request. REQ and DROP complete on ack; REQ then moves to HOLD.

## Timing

- Reset values:
  - State IDLE.
  - `req_addr`, `buf_inst`, `id_inst`, `id_pc` = 0.
  - `id_valid` = 0, `imem_req` = 0, `if_stall` = 1.
- Reset overrides everything, including an outstanding request. Memory must tolerate `imem_req` dropping mid-transaction on reset.
- First fetch:
  - Cycle 0: first cycle out of reset, state IDLE.
  - Cycle 1: REQ with `req_addr` = `pc`.
  - With zero-wait ack in cycle 1, `id_valid`=1 from cycle 2.
- Throughput: 1 instruction/cycle with same-cycle ack. N wait cycles add N bubbles per instruction.
- Flush in the ack cycle: fetch restarts from the target. Sequence is IDLE, then REQ of the target 2 cycles after the flush edge.
- `if_stall` is combinational from `imem_ack`, `id_shouldStall`, `ex_shouldJumpOrBranch` and `cpu_en`. It has no path from `imem_rdata`.

## Test plan

- Zero-wait memory returning word = addr ^ 32'hA5A5A5A5, `pc` advancing by 4 from 0: `id_inst` equals 0^A5A5A5A5, 4^A5A5A5A5, ... on consecutive cycles with `id_valid`=1, and `id_pc` = 0, 4, 8.
- 3-wait memory: `imem_addr` stays stable for 4 cycles per request, `if_stall`=1 for the 3 wait cycles, and 3 bubbles (`id_valid`=0, `id_inst`=NOP) precede each instruction.
- Ack arrives while `id_shouldStall`=1 for 2 cycles: state goes to HOLD, `imem_req`=0, the IF/ID register holds, and the buffered word appears in `id_inst` the cycle after the stall drops, with no duplicate fetch of that address.
- Flush during REQ wait at addr 0x10, target 0x40: `imem_addr` stays 0x10 until ack, the stale data never reaches ID, the next request is 0x40, and `id_valid`=0 until the 0x40 word arrives.
- Flush coinciding with `id_shouldStall` while in HOLD: the buffer is discarded, IF/ID is cleared to NOP with `id_valid`=0, and the state returns to IDLE.
- Reset asserted mid-REQ, and `cpu_en`=0 for 5 cycles mid-stream: on reset, all outputs return to reset values next cycle. With `cpu_en`=0, the outstanding request completes into HOLD, IF/ID is frozen, and fetch resumes in order once `cpu_en`=1.
